// File: rtl/dyn_scan_disp.sv
// Multiplexed seven-segment scan driver: holds DIGITS hex digits with decimal points and
// time-multiplexes them onto shared segment lines, with a dark gap at the start of every slot
// to suppress ghosting and optional leading-zero blanking.
module dyn_scan_disp #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic              Lz_en,
  input  logic              Wr_en,
  input  logic [2:0]        Wr_addr,
  input  logic [3:0]        Wr_data,
  input  logic              Wr_dp,
  output logic [7:0]        Seg,
  output logic [DIGITS-1:0] Sl,
  output logic [2:0]        Digit_idx
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DIGITS-1:0][3:0] val_q, val_d;
  logic [DIGITS-1:0]      dp_q, dp_d;
  logic [7:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      sl_q, sl_d;

  // Digit currently addressed by the scan, plus its leading-zero status.
  logic [3:0] cur_val;
  logic       cur_dp;
  logic       lz_blank;

  // Standard common-cathode hex patterns, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'h3F;
      4'h1:    p = 7'h06;
      4'h2:    p = 7'h5B;
      4'h3:    p = 7'h4F;
      4'h4:    p = 7'h66;
      4'h5:    p = 7'h6D;
      4'h6:    p = 7'h7D;
      4'h7:    p = 7'h07;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h6F;
      4'hA:    p = 7'h77;
      4'hB:    p = 7'h7C;
      4'hC:    p = 7'h39;
      4'hD:    p = 7'h5E;
      4'hE:    p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Digit register file update; out-of-range addresses match no entry and are dropped.
  always_comb begin
    val_d = val_q;
    dp_d  = dp_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (Wr_en && (Wr_addr == 3'(i))) begin
        val_d[i] = Wr_data;
        dp_d[i]  = Wr_dp;
      end
    end
  end

  // Scan FSM: IDLE -> BLANK (dead time) -> DRIVE -> BLANK of next digit; En low always parks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (En) state_d = StBlank;
      end
      StBlank: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(BLANK_CYC - 1)) state_d = StDrive;
      end
      StDrive: begin
        if (cnt_q == CntW'(SCAN_DIV - 1)) begin
          cnt_d   = '0;
          idx_d   = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
          state_d = StBlank;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    if (!En) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  // Select the scanned digit and decide whether it is a blankable leading zero.
  always_comb begin
    cur_val  = 4'h0;
    cur_dp   = 1'b0;
    lz_blank = Lz_en && (idx_q != 3'd0);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_val = val_q[i];
        cur_dp  = dp_q[i];
      end
      // Any non-zero or dotted digit at or above the slot stops it being a leading zero.
      if ((3'(i) >= idx_q) && ((val_q[i] != 4'h0) || dp_q[i])) lz_blank = 1'b0;
    end
  end

  // Next registered display outputs: dark unless driving a slot.
  always_comb begin
    seg_d = 8'h00;
    sl_d  = '1;
    if (state_q == StDrive) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx_q == 3'(i)) sl_d[i] = 1'b0;
      end
      // Suppression only applies with dp clear, so blanking the whole byte is safe.
      seg_d = lz_blank ? 8'h00 : {cur_dp, hex7(cur_val)};
    end
  end

  // State, digit storage and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      seg_q   <= 8'h00;
      sl_q    <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      seg_q   <= seg_d;
      sl_q    <= sl_d;
    end
  end

  assign Seg       = seg_q;
  assign Sl        = sl_q;
  assign Digit_idx = (state_q == StIdle) ? 3'd0 : idx_q;

endmodule

// File: tb/tb_dyn_scan_disp.sv
// Scoreboard bench for dyn_scan_disp: the driver pushes the expected per-cycle display
// (Sl, Seg, Digit_idx) for each clock; a negedge monitor pops and compares.
module tb_dyn_scan_disp;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;

  logic       Clk = 1'b0;
  logic       Reset, En, Lz_en, Wr_en, Wr_dp;
  logic [2:0] Wr_addr;
  logic [3:0] Wr_data;
  logic [7:0] Seg;
  logic [3:0] Sl;
  logic [2:0] Digit_idx;

  dyn_scan_disp #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Lz_en    (Lz_en),
    .Wr_en    (Wr_en),
    .Wr_addr  (Wr_addr),
    .Wr_data  (Wr_data),
    .Wr_dp    (Wr_dp),
    .Seg      (Seg),
    .Sl       (Sl),
    .Digit_idx(Digit_idx)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [3:0] sl;
    logic [7:0] seg;
    logic [2:0] di;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  string phase;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic push(input logic [3:0] sl, input logic [7:0] seg, input logic [2:0] di);
    exp_t e;
    e.name = phase;
    e.sl   = sl;
    e.seg  = seg;
    e.di   = di;
    exp_q.push_back(e);
  endtask

  // One clock: the expectation describes the outputs between this posedge and the next.
  task automatic cyc(input logic [3:0] sl, input logic [7:0] seg, input logic [2:0] di);
    @(posedge Clk);
    #1;
    push(sl, seg, di);
  endtask

  task automatic dark(input logic [2:0] di);
    cyc(4'hF, 8'h00, di);
  endtask

  function automatic logic [3:0] sel(input int k);
    return ~(4'b0001 << k);
  endfunction

  // Full slot: 2 dead cycles, 6 driven cycles; Digit_idx moves on with the last one.
  task automatic slot(input int k, input logic [7:0] seg);
    dark(3'(k));
    dark(3'(k));
    repeat (5) cyc(sel(k), seg, 3'(k));
    cyc(sel(k), seg, 3'((k + 1) % 4));
  endtask

  task automatic start();
    En = 1'b1;
    dark(3'd0);
  endtask

  task automatic stop();
    En = 1'b0;
    dark(3'd0);
  endtask

  // Register write while the display is parked dark.
  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic dp);
    Wr_en   = 1'b1;
    Wr_addr = a;
    Wr_data = d;
    Wr_dp   = dp;
    dark(3'd0);
    Wr_en   = 1'b0;
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (Sl !== mon_e.sl || Seg !== mon_e.seg || Digit_idx !== mon_e.di) begin
        n_fail++;
        $display("FAIL %s @%0t: got Sl=%b Seg=%h Digit_idx=%0d, want Sl=%b Seg=%h Digit_idx=%0d",
                 mon_e.name, $time, Sl, Seg, Digit_idx, mon_e.sl, mon_e.seg, mon_e.di);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; En = 1'b0; Lz_en = 1'b0; Wr_en = 1'b0;
    Wr_addr = 3'd0; Wr_data = 4'h0; Wr_dp = 1'b0;

    phase = "reset";
    dark(3'd0);
    dark(3'd0);
    Reset = 1'b0;

    phase = "basic_scan";
    wr(3'd0, 4'h1, 1'b0);
    wr(3'd1, 4'h2, 1'b0);
    wr(3'd2, 4'h3, 1'b0);
    wr(3'd3, 4'h4, 1'b0);
    start();
    slot(0, 8'h06);
    slot(1, 8'h5B);
    slot(2, 8'h4F);
    slot(3, 8'h66);
    slot(0, 8'h06);

    phase = "en_drop";
    dark(3'd1);
    dark(3'd1);
    cyc(sel(1), 8'h5B, 3'd1);
    En = 1'b0;
    cyc(sel(1), 8'h5B, 3'd0);
    dark(3'd0);
    dark(3'd0);

    phase = "restart";
    start();
    slot(0, 8'h06);
    stop();

    phase = "lz_on";
    wr(3'd0, 4'h5, 1'b0);
    wr(3'd1, 4'h0, 1'b0);
    wr(3'd2, 4'h0, 1'b0);
    wr(3'd3, 4'h0, 1'b0);
    Lz_en = 1'b1;
    start();
    slot(0, 8'h6D);
    slot(1, 8'h00);
    slot(2, 8'h00);
    slot(3, 8'h00);
    stop();

    phase = "lz_off";
    Lz_en = 1'b0;
    start();
    slot(0, 8'h6D);
    slot(1, 8'h3F);
    slot(2, 8'h3F);
    slot(3, 8'h3F);
    stop();

    phase = "dp_and_bad_addr";
    wr(3'd2, 4'hA, 1'b1);
    wr(3'd5, 4'h9, 1'b1);
    Lz_en = 1'b1;
    start();
    slot(0, 8'h6D);
    slot(1, 8'h3F);
    slot(2, 8'hF7);
    slot(3, 8'h00);
    stop();

    phase = "live_write";
    start();
    dark(3'd0);
    dark(3'd0);
    cyc(sel(0), 8'h6D, 3'd0);
    cyc(sel(0), 8'h6D, 3'd0);
    Wr_en = 1'b1; Wr_addr = 3'd0; Wr_data = 4'h8; Wr_dp = 1'b0;
    cyc(sel(0), 8'h6D, 3'd0);
    Wr_en = 1'b0;
    cyc(sel(0), 8'h7F, 3'd0);
    cyc(sel(0), 8'h7F, 3'd0);
    // Write lands on the same edge that advances to slot 1.
    Wr_en = 1'b1; Wr_addr = 3'd1; Wr_data = 4'h3; Wr_dp = 1'b0;
    cyc(sel(0), 8'h7F, 3'd1);
    Wr_en = 1'b0;
    slot(1, 8'h4F);
    slot(2, 8'hF7);
    slot(3, 8'h00);

    phase = "async_reset";
    dark(3'd0);
    dark(3'd0);
    cyc(sel(0), 8'h7F, 3'd0);
    cyc(sel(0), 8'h7F, 3'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    push(4'hF, 8'h00, 3'd0);
    dark(3'd0);
    Reset = 1'b0;

    phase = "post_reset";
    dark(3'd0);
    slot(0, 8'h3F);
    slot(1, 8'h00);
    stop();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge Clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dyn_scan_disp.md
DYN_SCAN_DISP -- requirements
Module: dyn_scan_disp

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clock cycles per digit slot (legal > BLANK_CYC+1).
REQ-003 SHALL have parameter BLANK_CYC, default 2, anti-ghost dead-time cycles at the start of each slot (legal 1..SCAN_DIV-2).
REQ-004 SHALL have port Clk  in  1  the single clock; all state changes on posedge Clk.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port En  in  1  scan enable; low means display dark.
REQ-007 SHALL have port Lz_en  in  1  leading-zero suppression enable.
REQ-008 SHALL have port Wr_en  in  1  digit-register write strobe.
REQ-009 SHALL have port Wr_addr  in  3  digit index to write; 0 is the least significant digit.
REQ-010 SHALL have port Wr_data  in  4  hex value to store.
REQ-011 SHALL have port Wr_dp  in  1  decimal-point bit to store.
REQ-012 SHALL have port Seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.
REQ-013 SHALL have port Sl  out  DIGITS  digit selects, active-low, one-hot-low when driving.
REQ-014 SHALL have port Digit_idx  out  3  index of the digit slot in progress.

Function
REQ-015 SHALL hold DIGITS x {4-bit value, dp} registers; a write with Wr_en=1 and Wr_addr<DIGITS SHALL update the register at the next posedge; Wr_addr>=DIGITS SHALL be ignored.
REQ-016 SHALL implement FSM states IDLE, BLANK, DRIVE with slot counter cnt (0..SCAN_DIV-1) and digit index idx (0..DIGITS-1).
REQ-017 IDLE: cnt=0, idx=0; on En=1 SHALL go to BLANK next cycle.
REQ-018 BLANK: cnt increments; at cnt==BLANK_CYC-1 SHALL go to DRIVE.
REQ-019 DRIVE: cnt increments; at cnt==SCAN_DIV-1 SHALL clear cnt, advance idx (DIGITS-1 wraps to 0) and go to BLANK.
REQ-020 En=0 in any state SHALL force IDLE at the next posedge.
REQ-021 Seg and Sl SHALL be registered, reflecting FSM state, idx and digit registers with exactly 1 cycle latency.
REQ-022 In IDLE or BLANK the registered outputs SHALL be Sl=all ones, Seg=8'h00.
REQ-023 In DRIVE the outputs SHALL be Sl bit idx =0 (others 1) and Seg = hex decode of digit[idx] with bit 7 = dp[idx].
REQ-024 Decode SHALL use standard patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 With Lz_en=1, digit i>0 SHALL show Seg=00 (Sl still asserted) when digit i and all higher digits are 0 with dp clear; digit 0 SHALL never be suppressed; a set dp SHALL defeat suppression of that digit.
REQ-026 A write to the digit currently in DRIVE SHALL appear on Seg within 2 cycles, with no glitch to other selects.
REQ-027 Digit_idx SHALL equal idx, zero-extended, and SHALL be 0 in IDLE.
REQ-028 Simultaneous write and slot advance SHALL both take effect; the new slot SHALL display the written value if addressed.

Reset
REQ-029 Reset=1 SHALL immediately (asynchronously) force state IDLE, cnt=0, idx=0, all digit values and dp to 0, Seg=8'h00, Sl=all ones, Digit_idx=0.
REQ-030 Reset asserted mid-slot SHALL abandon the slot; after release with En=1 scanning SHALL restart at idx 0 via BLANK.

Verification (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2)
REQ-031 Write 1,2,3,4 to addr 0..3, En=1 -> each slot: 2 cycles Sl=1111/Seg=00, then 6 cycles Sl=1110/Seg=06, next slot Sl=1101/Seg=5B, ..., Sl=0111/Seg=66, wrap to Sl=1110.
REQ-032 Digits {3:0}={0,0,0,5}, Lz_en=1 -> digits 3..1 Seg=00, digit 0 Seg=6D; Lz_en=0 -> digits 3..1 Seg=3F.
REQ-033 Write addr 2 value A with Wr_dp=1 -> slot 2 shows Seg=F7; write addr 5 -> no register change.
REQ-034 Drop En mid-DRIVE -> next cycle FSM IDLE, following cycle Sl=1111/Seg=00; raise En -> restart at idx 0.
REQ-035 Assert Reset between clock edges mid-DRIVE -> Sl=1111, Seg=00, digits cleared without a clock edge; release -> digit 0 shows 3F after BLANK_CYC+1 cycles.
